// File: rtl/rob_recovery_ctrl_pkg.sv
// ============================================================================
// rob_recovery_ctrl_pkg : shared types and constants for ROB exception recovery
// Rev 1.0
// ============================================================================
`default_nettype none

package rob_recovery_ctrl_pkg;

    localparam int PC_W_DEF   = 16;
    localparam int ROB_TAG_W  = 4;
    localparam int PREG_IDX_W = 5;

    localparam logic [1:0] SLOT_X = 2'd0;
    localparam logic [1:0] SLOT_Y = 2'd1;
    localparam logic [1:0] SLOT_Z = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        DRAIN    = 2'd2,
        REDIRECT = 2'd3
    } rec_state_t;

endpackage

`default_nettype wire

// File: rtl/rob_recovery_ctrl_oldest_exc_sel.sv
// ============================================================================
// rob_recovery_ctrl_oldest_exc_sel : picks the oldest excepting retire slot
// and the set of slots allowed to commit ahead of it.  Rev 1.0
// ============================================================================
`default_nettype none

module rob_recovery_ctrl_oldest_exc_sel
    import rob_recovery_ctrl_pkg::*;
(
    input  logic [2:0] valid_i,
    input  logic [2:0] exp_i,
    output logic       exc_any_o,
    output logic [1:0] exc_slot_o,
    output logic [2:0] mask_o
);

    logic [2:0] w_exc;

    assign w_exc     = valid_i & exp_i;
    assign exc_any_o = |w_exc;

    // Only slots strictly older than the oldest excepting one may commit.
    always_comb begin
        exc_slot_o = SLOT_X;
        mask_o     = valid_i;
        if (w_exc[0]) begin
            exc_slot_o = SLOT_X;
            mask_o     = 3'b000;
        end else if (w_exc[1]) begin
            exc_slot_o = SLOT_Y;
            mask_o     = {2'b00, valid_i[0]};
        end else if (w_exc[2]) begin
            exc_slot_o = SLOT_Z;
            mask_o     = {1'b0, valid_i[1:0]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/rob_recovery_ctrl.sv
// ============================================================================
// rob_recovery_ctrl : exception recovery sequencer (flush, drain, redirect)
// for the 3-wide retire port of the ROB.  Rev 1.0
// ============================================================================
`default_nettype none

module rob_recovery_ctrl
    import rob_recovery_ctrl_pkg::*;
#(
    parameter int               PC_W         = PC_W_DEF,
    parameter int               FLUSH_CYCLES = 2,
    parameter int               DRAIN_MIN    = 3,
    parameter logic [PC_W-1:0]  EXC_VEC      = PC_W'(16'h0100)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            retire_valid_x,
    input  logic            retire_valid_y,
    input  logic            retire_valid_z,
    input  logic            exp_x,
    input  logic            exp_y,
    input  logic            exp_z,
    input  logic [PC_W-1:0] pc_retire_x,
    input  logic [PC_W-1:0] pc_retire_y,
    input  logic [PC_W-1:0] pc_retire_z,
    input  logic            full_ROB,
    input  logic            busy_exec,
    output logic [2:0]      retire_mask,
    output logic            flush,
    output logic            freeze_front,
    output logic            stall_issue,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] epc,
    output logic [1:0]      exc_slot,
    output logic [7:0]      exc_count
);

    localparam int              CNT_W      = 8;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_MIN - 1);

    logic            sel_exc_any;
    logic [1:0]      sel_slot;
    logic [2:0]      sel_mask;
    logic [PC_W-1:0] sel_pc;

    rec_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic            flush_q;
    logic            freeze_q;
    logic            redirect_valid_q;
    logic [PC_W-1:0] redirect_pc_q;
    logic [PC_W-1:0] epc_q;
    logic [1:0]      exc_slot_q;
    logic [7:0]      exc_count_q;

    rob_recovery_ctrl_oldest_exc_sel u_sel (
        .valid_i    ({retire_valid_z, retire_valid_y, retire_valid_x}),
        .exp_i      ({exp_z, exp_y, exp_x}),
        .exc_any_o  (sel_exc_any),
        .exc_slot_o (sel_slot),
        .mask_o     (sel_mask)
    );

    always_comb begin
        case (sel_slot)
            SLOT_Y:  sel_pc = pc_retire_y;
            SLOT_Z:  sel_pc = pc_retire_z;
            default: sel_pc = pc_retire_x;
        endcase
    end

    assign retire_mask = (state_q == IDLE) ? sel_mask : 3'b000;
    assign stall_issue = full_ROB | (state_q != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            flush_q          <= 1'b0;
            freeze_q         <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            epc_q            <= '0;
            exc_slot_q       <= SLOT_X;
            exc_count_q      <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    redirect_valid_q <= 1'b0;
                    if (sel_exc_any) begin
                        epc_q      <= sel_pc;
                        exc_slot_q <= sel_slot;
                        if (exc_count_q != 8'hFF)
                            exc_count_q <= exc_count_q + 8'd1;
                        cnt_q    <= FLUSH_LOAD;
                        flush_q  <= 1'b1;
                        freeze_q <= 1'b1;
                        state_q  <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= DRAIN_LOAD;
                        flush_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DRAIN: begin
                    // Minimum dwell first, then wait for execution units to go idle.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (!busy_exec) begin
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= EXC_VEC;
                        state_q          <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    redirect_valid_q <= 1'b0;
                    freeze_q         <= 1'b0;
                    state_q          <= IDLE;
                end
                default: begin
                    flush_q          <= 1'b0;
                    freeze_q         <= 1'b0;
                    redirect_valid_q <= 1'b0;
                    state_q          <= IDLE;
                end
            endcase
        end
    end

    assign flush          = flush_q;
    assign freeze_front   = freeze_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign epc            = epc_q;
    assign exc_slot       = exc_slot_q;
    assign exc_count      = exc_count_q;

endmodule

`default_nettype wire

// File: tb/tb_rob_recovery_ctrl.sv
// ============================================================================
// tb_rob_recovery_ctrl : directed bench with a scoreboard of expected
// exception records, compared when the DUT strobes its redirect.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_rob_recovery_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        retire_valid_x = 1'b0, retire_valid_y = 1'b0, retire_valid_z = 1'b0;
    logic        exp_x = 1'b0, exp_y = 1'b0, exp_z = 1'b0;
    logic [15:0] pc_retire_x = 16'h0, pc_retire_y = 16'h0, pc_retire_z = 16'h0;
    logic        full_ROB = 1'b0;
    logic        busy_exec = 1'b0;
    logic [2:0]  retire_mask;
    logic        flush, freeze_front, stall_issue, redirect_valid;
    logic [15:0] redirect_pc, epc;
    logic [1:0]  exc_slot;
    logic [7:0]  exc_count;

    typedef struct {
        logic [15:0] epc;
        logic [1:0]  slot;
        logic [7:0]  cnt;
    } exp_rec_t;

    exp_rec_t sb[$];
    int total = 0;
    int bad   = 0;
    int m_count = 0;

    rob_recovery_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .retire_valid_x (retire_valid_x),
        .retire_valid_y (retire_valid_y),
        .retire_valid_z (retire_valid_z),
        .exp_x          (exp_x),
        .exp_y          (exp_y),
        .exp_z          (exp_z),
        .pc_retire_x    (pc_retire_x),
        .pc_retire_y    (pc_retire_y),
        .pc_retire_z    (pc_retire_z),
        .full_ROB       (full_ROB),
        .busy_exec      (busy_exec),
        .retire_mask    (retire_mask),
        .flush          (flush),
        .freeze_front   (freeze_front),
        .stall_issue    (stall_issue),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .epc            (epc),
        .exc_slot       (exc_slot),
        .exc_count      (exc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input logic [2:0] e);
        {retire_valid_z, retire_valid_y, retire_valid_x} = v;
        {exp_z, exp_y, exp_x} = e;
    endtask

    // Present a retire group in IDLE, check the commit mask, and record
    // the expected exception outcome; returns one cycle after the edge.
    task automatic fire(input logic [2:0] v, input logic [2:0] e);
        logic [2:0] x;
        logic [2:0] m;
        exp_rec_t   r;
        drive(v, e);
        #1;
        x = v & e;
        m = v;
        r.slot = 2'd0;
        r.epc  = pc_retire_x;
        if (x[0]) begin
            m = 3'b000;
        end else if (x[1]) begin
            m = {2'b00, v[0]};
            r.slot = 2'd1;
            r.epc  = pc_retire_y;
        end else if (x[2]) begin
            m = {1'b0, v[1:0]};
            r.slot = 2'd2;
            r.epc  = pc_retire_z;
        end
        chk("mask_idle", {29'd0, retire_mask}, {29'd0, m});
        if (x != 3'b000) begin
            m_count = (m_count == 255) ? 255 : m_count + 1;
            r.cnt   = 8'(m_count);
            sb.push_back(r);
        end
        step();
        drive(3'b000, 3'b000);
    endtask

    task automatic pop_check();
        exp_rec_t r;
        chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk("epc", {16'd0, epc}, {16'd0, r.epc});
            chk("exc_slot", {30'd0, exc_slot}, {30'd0, r.slot});
            chk("exc_count", {24'd0, exc_count}, {24'd0, r.cnt});
        end
    endtask

    // Walk the recovery sequence cycle by cycle starting in cycle T+1.
    task automatic run_seq(input int drain_len, input bit inject);
        for (int c = 1; c <= 2 + drain_len; c++) begin
            if (inject && c == 4) drive(3'b000, 3'b000);
            chk("flush_seq", {31'd0, flush}, {31'd0, c <= 2});
            chk("freeze_seq", {31'd0, freeze_front}, 32'd1);
            chk("redir_early", {31'd0, redirect_valid}, 32'd0);
            chk("stall_seq", {31'd0, stall_issue}, 32'd1);
            if (inject && c == 3) begin
                drive(3'b111, 3'b111);
                #1;
                chk("mask_busy", {29'd0, retire_mask}, 32'd0);
            end
            if (c == 2 + drain_len) busy_exec = 1'b0;
            step();
        end
        chk("redir_valid", {31'd0, redirect_valid}, 32'd1);
        chk("redir_pc", {16'd0, redirect_pc}, 32'h0100);
        chk("redir_freeze", {31'd0, freeze_front}, 32'd1);
        chk("redir_flush", {31'd0, flush}, 32'd0);
        pop_check();
        step();
        chk("post_redir", {31'd0, redirect_valid}, 32'd0);
        chk("post_freeze", {31'd0, freeze_front}, 32'd0);
        chk("post_stall", {31'd0, stall_issue}, 32'd0);
    endtask

    initial begin
        int n;
        #1;
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_freeze", {31'd0, freeze_front}, 32'd0);
        chk("rst_redir", {31'd0, redirect_valid}, 32'd0);
        chk("rst_count", {24'd0, exc_count}, 32'd0);
        chk("rst_epc", {16'd0, epc}, 32'd0);
        chk("rst_stall", {31'd0, stall_issue}, 32'd0);
        step();
        rst = 1'b1;
        step();

        drive(3'b111, 3'b000);
        #1;
        chk("mask_norm", {29'd0, retire_mask}, 32'd7);
        repeat (3) begin
            step();
            chk("norm_flush", {31'd0, flush}, 32'd0);
            chk("norm_count", {24'd0, exc_count}, 32'd0);
        end
        drive(3'b000, 3'b000);

        pc_retire_x = 16'h0040; pc_retire_y = 16'h0042; pc_retire_z = 16'h0044;
        fire(3'b111, 3'b010);
        run_seq(3, 1'b0);

        pc_retire_z = 16'h0a0e;
        busy_exec = 1'b1;
        fire(3'b111, 3'b100);
        run_seq(10, 1'b0);

        pc_retire_x = 16'h1230;
        fire(3'b001, 3'b001);
        run_seq(3, 1'b1);

        full_ROB = 1'b1;
        drive(3'b111, 3'b000);
        #1;
        chk("full_stall", {31'd0, stall_issue}, 32'd1);
        chk("full_mask", {29'd0, retire_mask}, 32'd7);
        repeat (3) begin
            step();
            chk("full_flush", {31'd0, flush}, 32'd0);
            chk("full_freeze", {31'd0, freeze_front}, 32'd0);
        end
        full_ROB = 1'b0;
        drive(3'b000, 3'b000);
        #1;
        chk("full_off", {31'd0, stall_issue}, 32'd0);

        fire(3'b111, 3'b010);
        chk("pre_rst_flush", {31'd0, flush}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_flush", {31'd0, flush}, 32'd0);
        chk("mid_freeze", {31'd0, freeze_front}, 32'd0);
        chk("mid_redir", {31'd0, redirect_valid}, 32'd0);
        chk("mid_rpc", {16'd0, redirect_pc}, 32'd0);
        chk("mid_epc", {16'd0, epc}, 32'd0);
        chk("mid_slot", {30'd0, exc_slot}, 32'd0);
        chk("mid_count", {24'd0, exc_count}, 32'd0);
        chk("mid_stall", {31'd0, stall_issue}, 32'd0);
        sb.delete();
        m_count = 0;
        step();
        rst = 1'b1;
        step();

        pc_retire_x = 16'h00aa; pc_retire_y = 16'h00bb; pc_retire_z = 16'h00cc;
        fire(3'b111, 3'b101);
        run_seq(3, 1'b0);

        for (int i = 0; i < 256; i++) begin
            pc_retire_y = 16'(i);
            fire(3'b011, 3'b010);
            n = 0;
            while (!redirect_valid && n < 20) begin
                step();
                n++;
            end
            chk("redir_timeout", {31'd0, redirect_valid}, 32'd1);
            if (redirect_valid) pop_check();
            step();
        end
        chk("sat_count", {24'd0, exc_count}, 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
